// File: rtl/obstacle_scroll_scheduler.sv
// Obstacle scroll scheduler: loads, scrolls, wraps and scores four obstacle slots.
// Slot 1 is packed into the MSBs of the shape and X buses. Internally slot i lives
// at array index NUM_SLOTS-i, so the packed arrays drive the buses directly.

// Per-slot scroll arithmetic: move left by step, or wrap by one PERIOD when the
// slot would leave the screen.
module obstacle_scroll_slot #(
  parameter int COORD_W = 11,
  parameter int PERIOD  = 640
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] step,
  output logic [COORD_W-1:0] x_nxt,
  output logic               retire
);
  // A wrapped slot always lands below PERIOD, so modulo-2^COORD_W arithmetic is exact.
  always_comb begin
    retire = (x < step);
    x_nxt  = retire ? (x + COORD_W'(PERIOD) - step) : (x - step);
  end
endmodule

module obstacle_scroll_scheduler #(
  parameter int SHAPE_W     = 3,
  parameter int COORD_W     = 11,
  parameter int SCREEN_W    = 640,
  parameter int SPACING     = 160,
  parameter int SPEED_W     = 3,
  parameter int SCORE_W     = 8,
  parameter int EMPTY_SHAPE = 0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   FRAME_TICK,
  input  logic                   START,
  input  logic                   CRASH,
  input  logic [SPEED_W-1:0]     SPEED,
  input  logic [SHAPE_W-1:0]     RAND_SHAPE,
  output logic [4*SHAPE_W-1:0]   BLOCK_SHAPE,
  output logic [4*COORD_W-1:0]   BLOCK_START_X,
  output logic [SCORE_W-1:0]     SCORE,
  output logic                   RUNNING
);
  localparam int NUM_SLOTS = 4;
  localparam int PERIOD    = NUM_SLOTS * SPACING;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FREEZE} state_t;

  state_t                              state;
  logic [1:0]                          k;        // array index being loaded; 3 = slot 1
  logic [NUM_SLOTS-1:0][SHAPE_W-1:0]   shp;
  logic [NUM_SLOTS-1:0][COORD_W-1:0]   xs;
  logic [NUM_SLOTS-1:0][COORD_W-1:0]   xs_nxt;
  logic [NUM_SLOTS-1:0]                retire;
  logic [COORD_W-1:0]                  step;
  logic [SHAPE_W-1:0]                  new_shape;
  logic [2:0]                          n_ret;
  logic [SCORE_W:0]                    score_sum;
  logic [SCORE_W-1:0]                  score;
  logic                                running;

  assign BLOCK_SHAPE   = shp;
  assign BLOCK_START_X = xs;
  assign SCORE         = score;
  assign RUNNING       = running;

  // Step size, replacement shape and saturating score for this frame.
  always_comb begin
    step      = (SPEED == '0) ? COORD_W'(1) : COORD_W'(SPEED);
    new_shape = (RAND_SHAPE == SHAPE_W'(EMPTY_SHAPE)) ? SHAPE_W'(1) : RAND_SHAPE;
    n_ret     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) n_ret = n_ret + 3'(retire[i]);
    score_sum = {1'b0, score} + (SCORE_W+1)'(n_ret);
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
      obstacle_scroll_slot #(.COORD_W(COORD_W), .PERIOD(PERIOD)) u_slot (
        .x      (xs[g]),
        .step   (step),
        .x_nxt  (xs_nxt[g]),
        .retire (retire[g])
      );
    end
  endgenerate

  // Game FSM with all slot state, score and RUNNING registered.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      k       <= 2'd3;
      score   <= '0;
      running <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shp[i] <= SHAPE_W'(EMPTY_SHAPE);
        xs[i]  <= COORD_W'(SCREEN_W);
      end
    end else begin
      case (state)
        IDLE, FREEZE: begin
          if (START) begin
            state <= LOAD;
            k     <= 2'd3;
            score <= '0;
          end
        end
        LOAD: begin
          xs[k]  <= COORD_W'(SCREEN_W + (NUM_SLOTS - 1 - int'(k)) * SPACING);
          shp[k] <= new_shape;
          if (k == 2'd0) begin
            state   <= RUN;
            running <= 1'b1;
          end else begin
            k <= k - 2'd1;
          end
        end
        RUN: begin
          // A crash freezes the field before any move in the same cycle.
          if (CRASH) begin
            state   <= FREEZE;
            running <= 1'b0;
          end else if (FRAME_TICK) begin
            xs <= xs_nxt;
            for (int i = 0; i < NUM_SLOTS; i++)
              if (retire[i]) shp[i] <= new_shape;
            score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_obstacle_scroll_scheduler.sv
// Bench for obstacle_scroll_scheduler: directed scenarios plus random play,
// every cycle compared against a slot-level behavioural model.
module tb_obstacle_scroll_scheduler;
  localparam int SHAPE_W = 3, COORD_W = 11, SCREEN_W = 640, SPACING = 160;
  localparam int SPEED_W = 3, SCORE_W = 8;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_FREEZE = 3;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b0, FRAME_TICK = 1'b0, START = 1'b0, CRASH = 1'b0;
  logic [SPEED_W-1:0]   SPEED = '0;
  logic [SHAPE_W-1:0]   RAND_SHAPE = '0;
  logic [4*SHAPE_W-1:0] BLOCK_SHAPE;
  logic [4*COORD_W-1:0] BLOCK_START_X;
  logic [SCORE_W-1:0]   SCORE;
  logic                 RUNNING;

  always #5 CLK = ~CLK;

  obstacle_scroll_scheduler dut (
    .CLK(CLK), .RST_N(RST_N), .FRAME_TICK(FRAME_TICK), .START(START), .CRASH(CRASH),
    .SPEED(SPEED), .RAND_SHAPE(RAND_SHAPE), .BLOCK_SHAPE(BLOCK_SHAPE),
    .BLOCK_START_X(BLOCK_START_X), .SCORE(SCORE), .RUNNING(RUNNING)
  );

  int n_chk = 0, n_pass = 0;
  int mx[1:4], ms[1:4], msc = 0, mph = P_IDLE, mk = 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [4*COORD_W-1:0] pack_x();
    logic [4*COORD_W-1:0] r;
    for (int i = 1; i <= 4; i++) r[(4-i)*COORD_W +: COORD_W] = COORD_W'(mx[i]);
    return r;
  endfunction

  function automatic logic [4*SHAPE_W-1:0] pack_s();
    logic [4*SHAPE_W-1:0] r;
    for (int i = 1; i <= 4; i++) r[(4-i)*SHAPE_W +: SHAPE_W] = SHAPE_W'(ms[i]);
    return r;
  endfunction

  // Advance the reference model by one clock using the current inputs.
  task automatic model_step();
    int st, nr, sh;
    sh = (RAND_SHAPE == 0) ? 1 : int'(RAND_SHAPE);
    if (!RST_N) begin
      mph = P_IDLE; msc = 0;
      for (int i = 1; i <= 4; i++) begin mx[i] = SCREEN_W; ms[i] = 0; end
    end else begin
      case (mph)
        P_IDLE, P_FREEZE: if (START) begin mph = P_LOAD; mk = 1; msc = 0; end
        P_LOAD: begin
          mx[mk] = SCREEN_W + (mk - 1) * SPACING;
          ms[mk] = sh;
          if (mk == 4) mph = P_RUN; else mk++;
        end
        P_RUN: begin
          if (CRASH) mph = P_FREEZE;
          else if (FRAME_TICK) begin
            st = (SPEED == 0) ? 1 : int'(SPEED);
            nr = 0;
            for (int i = 1; i <= 4; i++) begin
              if (mx[i] >= st) mx[i] = mx[i] - st;
              else begin mx[i] = mx[i] - st + 4 * SPACING; ms[i] = sh; nr++; end
            end
            msc = (msc + nr > 255) ? 255 : msc + nr;
          end
        end
        default: mph = P_IDLE;
      endcase
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge CLK);
    model_step();
    #1;
    chk("shape", BLOCK_SHAPE, pack_s());
    chk("x", BLOCK_START_X, pack_x());
    chk("score", SCORE, msc);
    chk("running", RUNNING, mph == P_RUN);
  endtask

  task automatic drive(input logic rst_n, input logic tick, input logic start,
                       input logic crash, input int speed, input int rs);
    RST_N = rst_n; FRAME_TICK = tick; START = start; CRASH = crash;
    SPEED = SPEED_W'(speed); RAND_SHAPE = SHAPE_W'(rs);
  endtask

  logic [4*COORD_W-1:0] saved_x;
  int guard;

  initial begin
    // Reset
    drive(0, 0, 0, 0, 0, 0); cyc(); cyc();
    chk("rst_shape", BLOCK_SHAPE, 0);
    chk("rst_x", BLOCK_START_X, {4{11'd640}});
    chk("rst_score", SCORE, 0);
    chk("rst_running", RUNNING, 0);

    // Tick in IDLE does nothing
    drive(1, 1, 0, 0, 3, 4); cyc();
    chk("idle_tick_x", BLOCK_START_X, {4{11'd640}});

    // Load with shapes 2,0,5,7
    drive(1, 0, 1, 0, 0, 4); cyc();
    drive(1, 1, 0, 1, 0, 2); cyc();
    drive(1, 1, 1, 0, 0, 0); cyc();
    drive(1, 0, 0, 0, 0, 5); cyc();
    chk("load_running_early", RUNNING, 0);
    drive(1, 0, 0, 0, 0, 7); cyc();
    chk("load_running", RUNNING, 1);
    chk("load_shape", BLOCK_SHAPE, {3'd2, 3'd1, 3'd5, 3'd7});
    chk("load_x", BLOCK_START_X, {11'd640, 11'd800, 11'd960, 11'd1120});

    // Move with SPEED=2 then SPEED=0
    drive(1, 1, 0, 0, 2, 6); cyc();
    drive(1, 0, 0, 0, 2, 6); cyc();
    chk("move2_x", BLOCK_START_X, {11'd638, 11'd798, 11'd958, 11'd1118});
    drive(1, 1, 0, 0, 0, 6); cyc();
    chk("move0_x", BLOCK_START_X, {11'd637, 11'd797, 11'd957, 11'd1117});

    // START in RUN is ignored
    drive(1, 0, 1, 0, 0, 6); cyc();
    chk("run_start_x", BLOCK_START_X, {11'd637, 11'd797, 11'd957, 11'd1117});

    // Walk slot 1 down to X=1, then wrap it
    for (int i = 0; i < 90; i++) begin drive(1, 1, 0, 0, 7, 5); cyc(); end
    drive(1, 1, 0, 0, 6, 5); cyc();
    chk("pre_wrap_x1", BLOCK_START_X[4*COORD_W-1 -: COORD_W], 1);
    drive(1, 1, 0, 0, 2, 3); cyc();
    chk("wrap_x1", BLOCK_START_X[4*COORD_W-1 -: COORD_W], 639);
    chk("wrap_s1", BLOCK_SHAPE[4*SHAPE_W-1 -: SHAPE_W], 3);
    chk("wrap_score", SCORE, 1);

    // Crash beats a simultaneous tick; later ticks ignored
    saved_x = pack_x();
    drive(1, 1, 0, 1, 4, 2); cyc();
    chk("crash_x", BLOCK_START_X, saved_x);
    chk("crash_running", RUNNING, 0);
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0, i[0], 4, 2); cyc(); end
    chk("freeze_x", BLOCK_START_X, saved_x);
    chk("freeze_score", SCORE, 1);
    drive(1, 0, 1, 0, 4, 2); cyc();
    chk("restart_score", SCORE, 0);
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0, 0, 0, $urandom_range(0, 7)); cyc(); end
    chk("restart_running", RUNNING, 1);

    // Saturate the score
    guard = 0;
    while (msc < 255 && guard < 30000) begin
      drive(1, 1, 0, 0, 7, $urandom_range(0, 7)); cyc(); guard++;
    end
    if (guard >= 30000) chk("sat_timeout", 0, 1);
    for (int i = 0; i < 200; i++) begin drive(1, 1, 0, 0, 7, $urandom_range(0, 7)); cyc(); end
    chk("sat_score", SCORE, 255);

    // Reset mid-RUN
    drive(0, 1, 0, 0, 7, 3); cyc();
    chk("midrst_x", BLOCK_START_X, {4{11'd640}});
    chk("midrst_score", SCORE, 0);
    chk("midrst_running", RUNNING, 0);

    // Random play
    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 299) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 7), $urandom_range(0, 7));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
